// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter slice.
//   state_t        : arbiter FSM states (IDLE, ADDR, DATA)
//   ARPROT_DEFAULT : idle value of the AR protection holding register
//   ADDR_W_DEF / DATA_W_DEF : default address / data widths
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [2:0]  ARPROT_DEFAULT = 3'b111;
  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 64;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-input request picker for axi_rd_arbiter. Purely combinational.
//   req[1:0]   : request lines from master 0 / master 1
//   last_grant : master that won the previous arbitration
//   prio_mode  : 0 = round-robin, 1 = master 1 always wins a tie
//   winner     : index of the selected master (only meaningful when |req)
module rr_arb2
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       prio_mode,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = prio_mode ? 1'b1 : ~last_grant;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave arbiter for the AXI-style read channel.
// Master 0 (instruction fetch) and master 1 (load unit) share one slave read
// port. One master is granted per transaction; the grant is held until the
// R beat carrying RLAST completes.
// Ports:
//   ACLK, ARESET           : clock, synchronous active-high reset
//   m0_* / m1_*            : AR request and R response of each master
//   s_*                    : AR request and R response toward the slave
//   busy                   : transaction in flight (state != IDLE)
//   grant_id               : currently or last granted master
//   timeout_err            : sticky watchdog error (DATA phase stalled)
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [2:0]        m0_arprot,
  output logic              m0_arready,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic              m0_rlast,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [2:0]        m1_arprot,
  output logic              m1_arready,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic              m1_rlast,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [2:0]        s_arprot,
  input  logic              s_arready,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic              s_rlast,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy,
  output logic              grant_id,
  output logic              timeout_err
);

  localparam int unsigned     WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  state_t            state;
  logic              last_grant;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [2:0]        ar_prot_q;
  logic [WD_W-1:0]   wd_cnt;
  logic [WD_W-1:0]   wd_inc;
  logic              winner;
  logic              r_hs;

  rr_arb2 u_rr_arb2 (
    .req        ({m1_arvalid, m0_arvalid}),
    .last_grant (last_grant),
    .prio_mode  (PRIO_MODE != 0),
    .winner     (winner)
  );

  assign r_hs   = (state == DATA) && s_rvalid && s_rready;
  assign wd_inc = wd_cnt + WD_W'(1);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;
      ar_addr_q   <= '0;
      ar_prot_q   <= ARPROT_DEFAULT;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            grant_id  <= winner;
            ar_addr_q <= winner ? m1_araddr : m0_araddr;
            ar_prot_q <= winner ? m1_arprot : m0_arprot;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (s_arready) begin
            state      <= DATA;
            last_grant <= grant_id;
            wd_cnt     <= '0;
          end
        end
        DATA: begin
          // Counter saturates at the limit; the error flag sets on the edge
          // that brings the count up to TIMEOUT and then stays set.
          if (r_hs) begin
            wd_cnt <= '0;
          end else if (wd_cnt != WD_LIMIT) begin
            wd_cnt <= wd_inc;
            if ((TIMEOUT != 0) && (wd_inc == WD_LIMIT)) begin
              timeout_err <= 1'b1;
            end
          end
          if (r_hs && s_rlast) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    s_arvalid  = (state == ADDR);
    s_araddr   = '0;
    s_arprot   = '0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rlast   = 1'b0;
    m0_rdata   = '0;
    m1_rvalid  = 1'b0;
    m1_rlast   = 1'b0;
    m1_rdata   = '0;
    if (state != IDLE) begin
      s_araddr = ar_addr_q;
      s_arprot = ar_prot_q;
    end
    if (state == ADDR) begin
      m0_arready = !grant_id && s_arready;
      m1_arready =  grant_id && s_arready;
    end
    if (state == DATA) begin
      s_rready = grant_id ? m1_rready : m0_rready;
      if (grant_id) begin
        m1_rvalid = s_rvalid;
        m1_rlast  = s_rlast;
        m1_rdata  = s_rdata;
      end else begin
        m0_rvalid = s_rvalid;
        m0_rlast  = s_rlast;
        m0_rdata  = s_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter. dut_a: round-robin, TIMEOUT=8.
// dut_b: fixed priority to master 1, default TIMEOUT; shares all inputs.
module tb_axi_rd_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        m0_arvalid, m1_arvalid;
  logic [31:0] m0_araddr, m1_araddr;
  logic [2:0]  m0_arprot, m1_arprot;
  logic        m0_rready, m1_rready;
  logic        s_arready, s_rvalid, s_rlast;
  logic [63:0] s_rdata;

  logic        a_m0_arready, a_m0_rvalid, a_m0_rlast, a_m1_arready, a_m1_rvalid, a_m1_rlast;
  logic [63:0] a_m0_rdata, a_m1_rdata;
  logic        a_s_arvalid, a_s_rready, a_busy, a_grant_id, a_timeout_err;
  logic [31:0] a_s_araddr;
  logic [2:0]  a_s_arprot;

  logic        b_m0_arready, b_m0_rvalid, b_m0_rlast, b_m1_arready, b_m1_rvalid, b_m1_rlast;
  logic [63:0] b_m0_rdata, b_m1_rdata;
  logic        b_s_arvalid, b_s_rready, b_busy, b_grant_id, b_timeout_err;
  logic [31:0] b_s_araddr;
  logic [2:0]  b_s_arprot;

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .PRIO_MODE(0), .TIMEOUT(8)) dut_a (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
    .m0_arready(a_m0_arready), .m0_rvalid(a_m0_rvalid), .m0_rready(m0_rready),
    .m0_rlast(a_m0_rlast), .m0_rdata(a_m0_rdata),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot),
    .m1_arready(a_m1_arready), .m1_rvalid(a_m1_rvalid), .m1_rready(m1_rready),
    .m1_rlast(a_m1_rlast), .m1_rdata(a_m1_rdata),
    .s_arvalid(a_s_arvalid), .s_araddr(a_s_araddr), .s_arprot(a_s_arprot),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rready(a_s_rready),
    .s_rlast(s_rlast), .s_rdata(s_rdata),
    .busy(a_busy), .grant_id(a_grant_id), .timeout_err(a_timeout_err)
  );

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .PRIO_MODE(1), .TIMEOUT(1023)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
    .m0_arready(b_m0_arready), .m0_rvalid(b_m0_rvalid), .m0_rready(m0_rready),
    .m0_rlast(b_m0_rlast), .m0_rdata(b_m0_rdata),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot),
    .m1_arready(b_m1_arready), .m1_rvalid(b_m1_rvalid), .m1_rready(m1_rready),
    .m1_rlast(b_m1_rlast), .m1_rdata(b_m1_rdata),
    .s_arvalid(b_s_arvalid), .s_araddr(b_s_araddr), .s_arprot(b_s_arprot),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rready(b_s_rready),
    .s_rlast(s_rlast), .s_rdata(s_rdata),
    .busy(b_busy), .grant_id(b_grant_id), .timeout_err(b_timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic nxt();
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    nxt();
    ARESET = 1'b1;
    nxt();
    ARESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int k;
    int hs;
    logic [31:0] held_addr;
    logic [0:5] rr_pat;

    ARESET = 1'b1;
    m0_arvalid = 0; m1_arvalid = 0;
    m0_araddr = '0; m1_araddr = '0;
    m0_arprot = '0; m1_arprot = '0;
    m0_rready = 0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = '0;

    // Reset state
    nxt(); nxt(); #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_grant", a_grant_id, 0);
    chk("rst_terr", a_timeout_err, 0);
    chk("rst_s_arvalid", a_s_arvalid, 0);
    chk("rst_s_araddr", a_s_araddr, 0);
    chk("rst_s_arprot", a_s_arprot, 0);
    chk("rst_s_rready", a_s_rready, 0);
    chk("rst_m0_arready", a_m0_arready, 0);
    nxt(); ARESET = 1'b0;

    // Lone request from m0
    nxt();
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arprot = 3'b010;
    s_arready = 1; m0_rready = 1;
    #1;
    chk("t1_idle_s_arvalid", a_s_arvalid, 0);
    chk("t1_idle_m0_arready", a_m0_arready, 0);
    nxt(); #1;
    chk("t1_addr_s_arvalid", a_s_arvalid, 1);
    chk("t1_addr_s_araddr", a_s_araddr, 64'h8000_0000);
    chk("t1_addr_s_arprot", a_s_arprot, 3'b010);
    chk("t1_addr_m0_arready", a_m0_arready, 1);
    chk("t1_addr_m1_arready", a_m1_arready, 0);
    chk("t1_addr_busy", a_busy, 1);
    nxt();
    m0_arvalid = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 64'h1122_3344_5566_7788;
    #1;
    chk("t1_data_m0_rvalid", a_m0_rvalid, 1);
    chk("t1_data_m0_rdata", a_m0_rdata, 64'h1122_3344_5566_7788);
    chk("t1_data_m0_rlast", a_m0_rlast, 1);
    chk("t1_data_m1_rvalid", a_m1_rvalid, 0);
    chk("t1_data_m1_rdata", a_m1_rdata, 0);
    chk("t1_data_s_rready", a_s_rready, 1);
    chk("t1_data_s_arvalid", a_s_arvalid, 0);
    nxt();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("t1_done_busy", a_busy, 0);
    chk("t1_done_m0_rvalid", a_m0_rvalid, 0);

    // Simultaneous requests: dut_a round-robin, dut_b fixed priority
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0000;
    m1_arvalid = 1; m1_araddr = 32'h8000_1000;
    s_arready = 1; m0_rready = 1; m1_rready = 1;
    nxt(); #1;
    chk("t2_a_grant", a_grant_id, 0);
    chk("t2_a_araddr0", a_s_araddr, 64'h8000_0000);
    chk("t2_a_m0_arready", a_m0_arready, 1);
    chk("t2_a_m1_arready", a_m1_arready, 0);
    chk("t2_b_grant", b_grant_id, 1);
    chk("t2_b_araddr0", b_s_araddr, 64'h8000_1000);
    chk("t2_b_m1_arready", b_m1_arready, 1);
    chk("t2_b_m0_arready", b_m0_arready, 0);
    nxt();
    m0_arvalid = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 64'hAAAA_0000_AAAA_0000;
    #1;
    chk("t2_a_m0_rdata", a_m0_rdata, 64'hAAAA_0000_AAAA_0000);
    chk("t2_a_m1_rvalid", a_m1_rvalid, 0);
    chk("t2_b_m1_rvalid", b_m1_rvalid, 1);
    chk("t2_b_m1_rdata", b_m1_rdata, 64'hAAAA_0000_AAAA_0000);
    chk("t2_b_m0_rvalid", b_m0_rvalid, 0);
    nxt();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("t2_a_bubble_busy", a_busy, 0);
    chk("t2_a_bubble_s_arvalid", a_s_arvalid, 0);
    nxt(); #1;
    chk("t2_a_grant2", a_grant_id, 1);
    chk("t2_a_araddr1", a_s_araddr, 64'h8000_1000);
    chk("t2_a_m1_arready2", a_m1_arready, 1);
    chk("t2_a_m0_arready2", a_m0_arready, 0);
    nxt();
    m1_arvalid = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 64'hBBBB_1111_BBBB_1111;
    #1;
    chk("t2_a_m1_rdata", a_m1_rdata, 64'hBBBB_1111_BBBB_1111);
    chk("t2_a_m0_rvalid2", a_m0_rvalid, 0);
    nxt();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("t2_a_done_busy", a_busy, 0);

    // Slave backpressure on a lone m1 request
    do_reset();
    m1_arvalid = 1; m1_araddr = 32'h1234_5678; m1_arprot = 3'b001;
    s_arready = 0; m1_rready = 1; m0_rready = 1;
    held_addr = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      nxt(); #1;
      chk("t4_ar_s_arvalid", a_s_arvalid, 1);
      chk("t4_ar_araddr_stable", a_s_araddr, {32'h0, held_addr});
      chk("t4_ar_m1_arready_low", a_m1_arready, 0);
      chk("t4_ar_m1_rvalid", a_m1_rvalid, 0);
    end
    s_arready = 1;
    #1;
    chk("t4_ar_m1_arready_high", a_m1_arready, 1);
    chk("t4_ar_m0_arready", a_m0_arready, 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      m1_arvalid = 0; s_arready = 0;
      s_rvalid = 0; s_rlast = 1; s_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      chk("t4_r_m1_rvalid_low", a_m1_rvalid, 0);
      chk("t4_r_busy", a_busy, 1);
      chk("t4_r_s_rready", a_s_rready, 1);
    end
    s_rvalid = 1; s_rdata = 64'h0000_0000_0000_0055;
    #1;
    chk("t4_r_m1_rvalid_high", a_m1_rvalid, 1);
    chk("t4_r_m1_rdata", a_m1_rdata, 64'h55);
    chk("t4_r_m0_rvalid", a_m0_rvalid, 0);
    nxt();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("t4_done_busy", a_busy, 0);
    chk("t4_no_terr", a_timeout_err, 0);

    // 4-beat burst to m0 with toggling rready
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h0000_0100; s_arready = 1;
    nxt(); #1;
    chk("t5_addr_s_araddr", a_s_araddr, 64'h100);
    rr_pat = 6'b101101;
    k = 0; hs = 0;
    for (int c = 0; c < 6; c++) begin
      nxt();
      m0_arvalid = 0;
      m0_rready = rr_pat[c];
      s_rvalid = 1; s_rdata = 64'h1000 + 64'(k); s_rlast = (k == 3);
      #1;
      chk("t5_busy", a_busy, 1);
      chk("t5_m0_rvalid", a_m0_rvalid, 1);
      chk("t5_m0_rdata", a_m0_rdata, 64'h1000 + 64'(k));
      chk("t5_s_rready", a_s_rready, {63'h0, rr_pat[c]});
      if (rr_pat[c]) begin
        k++; hs++;
      end
    end
    nxt();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("t5_handshakes", 64'(hs), 4);
    chk("t5_done_busy", a_busy, 0);

    // Watchdog: TIMEOUT=8, slave never responds
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h0000_2000; s_arready = 1; m0_rready = 1;
    nxt(); #1;
    chk("t6_addr_s_arvalid", a_s_arvalid, 1);
    for (int c = 1; c <= 8; c++) begin
      nxt();
      m0_arvalid = 0;
      #1;
      chk("t6_terr_low", a_timeout_err, 0);
      chk("t6_busy", a_busy, 1);
    end
    nxt(); #1;
    chk("t6_terr_set", a_timeout_err, 1);
    nxt(); nxt(); #1;
    chk("t6_terr_sticky", a_timeout_err, 1);
    chk("t6_still_data", a_s_rready, 1);
    ARESET = 1'b1;
    nxt(); #1;
    chk("t6_rst_terr", a_timeout_err, 0);
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_s_rready", a_s_rready, 0);
    chk("t6_rst_s_arvalid", a_s_arvalid, 0);
    ARESET = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
